// File: rtl/sisc_mem_resp.sv
// SISC memory responder: single-port word store behind a req/ack handshake.
// Each request is latched, held for a fixed number of wait states, then answered.
module sisc_mem_resp #(
  parameter int DEPTH   = 256,
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 1
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          ack,
  output logic          err,
  output logic          busy
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] mem [DEPTH];

  logic in_range;
  logic access;

  assign in_range = {1'b0, addr_q} < LIMIT;
  assign access   = (state == WAIT) && (cnt == 4'd0);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (access && we_q && in_range)
      mem[addr_q[IW-1:0]] <= wdata_q;
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= we ? 4'(WR_WAIT)
                          : 4'(RD_WAIT);
            busy    <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!we_q)
              rdata <= in_range
                     ? mem[addr_q[IW-1:0]]
                     : '0;
            ack   <= 1'b1;
            err   <= !in_range;
            state <= RESP;
          end
        end
        RESP: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
